// File: rtl/bitserial_alu_sequencer.sv
// ---------------------------------------------------------------------------
// bitserial_alu_sequencer
//   Runs a shared 1-bit, eight-function logic unit over W-bit operands, one
//   bit per clock, LSB first. A command (op, a, b) is taken over a
//   valid/ready handshake. The block drives the unit's a/b/sel inputs and
//   shifts the unit's 1-bit answer into a result register. The assembled
//   W-bit word is then offered over a second valid/ready handshake.
//
//   Ports
//     clk, rst_n          clock (rising edge), async active-low reset
//     in_valid/in_ready   command handshake; op/a/b are sampled on accept
//     op[2:0]             0 NAND,1 AND,2 OR,3 NOR,4 XOR,5 XNOR,6/7 NOT a
//     a[W-1:0], b[W-1:0]  operands
//     alu_a/alu_b/alu_sel drive to the external function unit (0 outside RUN)
//     alu_out             combinational answer from the unit
//     out_valid/out_ready result handshake
//     result[W-1:0]       assembled result (0 outside DONE)
//     busy                high while an operation is in flight (RUN/DONE)
// ---------------------------------------------------------------------------
module bitserial_alu_sequencer #(
  parameter  int W  = 8,
  localparam int CW = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         alu_a,
  output logic         alu_b,
  output logic [2:0]   alu_sel,
  input  logic         alu_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  state_e        state_q, state_d;
  logic [W-1:0]  a_sh_q, b_sh_q, res_sh_q;
  logic [2:0]    op_q;
  logic [CW-1:0] cnt_q;

  logic load;      // command accepted this edge
  logic run;       // one bit processed this edge
  logic last_bit;  // this edge processes the MSB

  assign load     = (state_q == S_IDLE) && in_valid;
  assign run      = (state_q == S_RUN);
  assign last_bit = run && (cnt_q == CNT_LAST);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid)  state_d = S_RUN;
      S_RUN:   if (last_bit)  state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs. All are decoded from registered state only, so neither
  // ready nor valid has a combinational path from the opposite handshake.
  // -------------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    alu_a     = 1'b0;
    alu_b     = 1'b0;
    alu_sel   = 3'd0;
    result    = '0;
    case (state_q)
      S_IDLE: in_ready = 1'b1;
      S_RUN: begin
        busy    = 1'b1;
        alu_a   = a_sh_q[0];
        alu_b   = b_sh_q[0];
        alu_sel = op_q;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        result    = res_sh_q;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath. Operands shift right so bit 0 always feeds the unit; the
  // answer enters at the MSB so after W shifts the first (LSB) answer has
  // reached bit 0. Everything is frozen in IDLE (no load) and DONE.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      op_q     <= 3'd0;
      cnt_q    <= '0;
    end else if (load) begin
      a_sh_q   <= a;
      b_sh_q   <= b;
      res_sh_q <= '0;
      op_q     <= op;
      cnt_q    <= '0;
    end else if (run) begin
      a_sh_q   <= {1'b0, a_sh_q[W-1:1]};
      b_sh_q   <= {1'b0, b_sh_q[W-1:1]};
      res_sh_q <= {alu_out, res_sh_q[W-1:1]};
      cnt_q    <= last_bit ? '0 : cnt_q + 1'b1;
    end
  end

endmodule
